exec_unit: RTL and testbench
============================

// Module: exec_unit
// PURPOSE
//  Execute stage of the 8-bit two-byte-instruction CPU, downstream of the fetch/memory path.
//  - Consumes latched instruction bytes ira (opcode) and irb (operand) during the execa/execb stage strobes.
//  - Owns the accumulator and Z/C flags, drives RAM data-path requests and PC redirects.
//  - Raises halt back to the stage controller.
// PARAMETERS
//  DW  8  data/accumulator width
//  AW  8  RAM address width; irb[AW-1:0] is the operand address/target
// PORTS
//  clk        in   1   single clock; all state updates on rising edge
//  rst        in   1   synchronous reset, active-low (0 = reset)
//  execa      in   1   execute phase A strobe from stage controller
//  execb      in   1   execute phase B strobe from stage controller
//  ira        in   DW  opcode byte; op = ira[7:4], ira[3:0] ignored
//  irb        in   DW  operand byte: immediate, RAM address or jump target
//  mem_rdata  in   DW  RAM read data; valid in execb for a read issued in execa
//  mem_addr   out  AW  RAM address request (= irb during execa, else 0)
//  mem_wdata  out  DW  RAM write data (= acc during execa of ST, else 0)
//  mem_rden   out  1   RAM read enable request
//  mem_wren   out  1   RAM write enable request
//  pc_load    out  1   one-cycle PC load strobe
//  pc_target  out  AW  PC load value (= irb when pc_load, else 0)
//  acc        out  DW  accumulator
//  flag_z     out  1   zero flag
//  flag_c     out  1   carry/borrow flag
//  halt       out  1   sticky halt to stage controller
// BEHAVIOUR
//  - Reset (rst==0 at posedge): acc, flag_z, flag_c and halt all clear to 0. Combinational outputs follow
//    the cleared state. Reset mid-instruction abandons it; no partial acc or flag update.
//  - Opcodes: 0 NOP, 1 LDI acc=irb, 2 LD acc=M[irb], 3 ST M[irb]=acc, 4 ADD acc+=M[irb],
//    5 SUB acc-=M[irb], 6 AND, 7 OR, 8 JMP, 9 JZ (if Z), A JC (if C), F HLT; B-E undefined.
//  - execa cycle:
//    - LD/ADD/SUB/AND/OR: mem_rden=1, mem_addr=irb.
//    - ST: mem_wren=1, mem_addr=irb, mem_wdata=acc.
//    - HLT: halt is set at the end of this cycle.
//    - No register updates in execa except halt.
//  - execb cycle:
//    - LDI/LD/ALU ops write acc at the end of this cycle (1-cycle latency after read issue).
//    - JMP, or JZ/JC with the flag taken: pc_load=1 and pc_target=irb, combinational in execb.
//  - Arithmetic, DW-bit modular:
//    - ADD: C = carry-out of acc+M.
//    - SUB: C = borrow (acc < M).
//    - AND/OR/LD/LDI: C unchanged.
//    - Z = (new acc == 0) on every acc write.
//    - Wrap example: 0xFF+0x01 -> acc=0x00, Z=1, C=1.
//  - Flags are sampled for JZ/JC using the value held before execb.
//  - Unchanged state: ST, NOP, jumps and HLT do not alter acc or flags.
//  - Halt: once set, halt stays 1 until reset. All strobes are ignored and every request output is held at 0.
//  - If execa and execb are both high, the cycle is treated as idle: no requests, no updates. A simulation
//    assertion flags it.
//  - When neither strobe is high, all request outputs are 0.
// CONFIGURATION
//  EXEC_ILLEGAL_TRAP_EN
//   - Defined: an undefined opcode (B-E) sets halt at the end of execa.
//   - Not defined: undefined opcodes execute as NOP.
// STRUCTURE
//  - Package exec_pkg: 4-bit opcode localparams (OP_NOP..OP_HLT) and ALU-select encoding.
//  - Sub-module exec_alu (combinational): inputs a, b, sel; outputs y, carry. Instantiated once.
//  - Decode, request muxing and registers live in exec_unit.
// TESTING
//  1. Reset: rst=0 for 2 cycles after random state -> acc=0, Z=0, C=0, halt=0, all requests 0.
//  2. LDI 0x7F, then ADD with M[0x10]=0x81:
//     - acc=0x00, Z=1, C=1.
//     - mem_rden=1 and mem_addr=0x10 in execa only.
//  3. ST with acc=0x5A, irb=0x20 -> in execa: mem_wren=1, mem_addr=0x20, mem_wdata=0x5A; acc unchanged.
//  4. JZ 0x33:
//     - With Z=1 -> pc_load=1, pc_target=0x33 in execb only.
//     - With Z=0 -> pc_load stays 0.
//  5. HLT, then further strobes with LDI 0x11 -> halt=1 from the cycle after execa; acc unchanged;
//     rst=0 clears halt.
//  6. Opcode 0xC0:
//     - With EXEC_ILLEGAL_TRAP_EN -> halt=1.
//     - Without -> NOP, halt=0.
//     - Also: execa and execb high together -> no updates.

Source files
------------

// File: rtl/exec_pkg.sv
// exec_pkg: shared opcode encodings and ALU-select type for the execute stage.
// Contents:
//   OP_NOP..OP_HLT  4-bit opcode values (ira[7:4])
//   alu_sel_e       ALU operation select
//   is_illegal()    true for the undefined opcode range B-E
package exec_pkg;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_LD  = 4'h2;
  localparam logic [3:0] OP_ST  = 4'h3;
  localparam logic [3:0] OP_ADD = 4'h4;
  localparam logic [3:0] OP_SUB = 4'h5;
  localparam logic [3:0] OP_AND = 4'h6;
  localparam logic [3:0] OP_OR  = 4'h7;
  localparam logic [3:0] OP_JMP = 4'h8;
  localparam logic [3:0] OP_JZ  = 4'h9;
  localparam logic [3:0] OP_JC  = 4'hA;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,  // y = b (loads)
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4
  } alu_sel_e;

  function automatic logic is_illegal(input logic [3:0] op);
    return (op >= 4'hB) && (op <= 4'hE);
  endfunction

endpackage

// File: rtl/exec_alu.sv
// exec_alu: combinational DW-bit ALU for the execute stage.
// Ports:
//   a      in  DW  accumulator operand
//   b      in  DW  memory / immediate operand
//   sel    in      operation select (alu_sel_e)
//   y      out DW  result, modulo 2^DW
//   carry  out 1   ADD: carry-out; SUB: borrow (a < b); else 0
module exec_alu
  import exec_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  input  alu_sel_e      sel,
  output logic [DW-1:0] y,
  output logic          carry
);

  always_comb begin
    y     = b;
    carry = 1'b0;
    unique case (sel)
      ALU_ADD: {carry, y} = {1'b0, a} + {1'b0, b};
      // Top bit of the widened difference is set exactly when a < b.
      ALU_SUB: {carry, y} = {1'b0, a} - {1'b0, b};
      ALU_AND: y = a & b;
      ALU_OR:  y = a | b;
      default: y = b;
    endcase
  end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: execute stage of the 8-bit two-byte-instruction CPU.
// Owns the accumulator and Z/C flags, issues RAM requests in execa, writes
// results and redirects the PC in execb, and raises a sticky halt.
// Ports:
//   clk, rst            clock; synchronous active-low reset
//   execa, execb        stage strobes (both high = idle cycle)
//   ira, irb            opcode byte (op = ira[7:4]) and operand byte
//   mem_rdata           RAM read data, valid in execb
//   mem_addr/wdata/rden/wren  RAM request, zero when not requesting
//   pc_load, pc_target  PC redirect strobe and target
//   acc, flag_z, flag_c architectural state
//   halt                sticky halt
// Configuration macro: EXEC_ILLEGAL_TRAP_EN - opcodes B-E halt in execa
// instead of executing as NOP.
module exec_unit
  import exec_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          execa,
  input  logic          execb,
  input  logic [DW-1:0] ira,
  input  logic [DW-1:0] irb,
  input  logic [DW-1:0] mem_rdata,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  output logic          mem_rden,
  output logic          mem_wren,
  output logic          pc_load,
  output logic [AW-1:0] pc_target,
  output logic [DW-1:0] acc,
  output logic          flag_z,
  output logic          flag_c,
  output logic          halt
);

  logic [DW-1:0] acc_q, acc_d;
  logic          z_q, z_d, c_q, c_d, halt_q, halt_d;

  logic [3:0]    op;
  logic          act_a, act_b;
  logic          acc_we, c_we, halt_set;
  alu_sel_e      alu_sel;
  logic [DW-1:0] alu_b, alu_y;
  logic          alu_c;

  assign op = ira[DW-1:DW-4];

  // Low opcode nibble carries no meaning.
  logic unused_ira;
  assign unused_ira = ^ira[DW-5:0];

  // Halt and the double-strobe case both suppress all activity.
  assign act_a = execa & ~execb & ~halt_q;
  assign act_b = execb & ~execa & ~halt_q;

  always_comb begin
    alu_sel  = ALU_PASS;
    alu_b    = mem_rdata;
    acc_we   = 1'b0;
    c_we     = 1'b0;
    halt_set = 1'b0;
    mem_rden = 1'b0;
    mem_wren = 1'b0;
    pc_load  = 1'b0;
    case (op)
      OP_NOP: ;
      OP_LDI: begin alu_b = irb; acc_we = act_b; end
      OP_LD:  begin mem_rden = act_a; acc_we = act_b; end
      OP_ST:  mem_wren = act_a;
      OP_ADD: begin mem_rden = act_a; acc_we = act_b; c_we = act_b; alu_sel = ALU_ADD; end
      OP_SUB: begin mem_rden = act_a; acc_we = act_b; c_we = act_b; alu_sel = ALU_SUB; end
      OP_AND: begin mem_rden = act_a; acc_we = act_b; alu_sel = ALU_AND; end
      OP_OR:  begin mem_rden = act_a; acc_we = act_b; alu_sel = ALU_OR;  end
      // Branch conditions use the flags as registered before this execb.
      OP_JMP: pc_load = act_b;
      OP_JZ:  pc_load = act_b & z_q;
      OP_JC:  pc_load = act_b & c_q;
      OP_HLT: halt_set = act_a;
      default: begin
`ifdef EXEC_ILLEGAL_TRAP_EN
        halt_set = act_a & is_illegal(op);
`else
        halt_set = 1'b0;
`endif
      end
    endcase
  end

  exec_alu #(.DW(DW)) u_alu (
    .a     (acc_q),
    .b     (alu_b),
    .sel   (alu_sel),
    .y     (alu_y),
    .carry (alu_c)
  );

  always_comb begin
    acc_d  = acc_we ? alu_y : acc_q;
    z_d    = acc_we ? (alu_y == '0) : z_q;
    c_d    = c_we ? alu_c : c_q;
    halt_d = halt_q | halt_set;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      acc_q  <= '0;
      z_q    <= 1'b0;
      c_q    <= 1'b0;
      halt_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      z_q    <= z_d;
      c_q    <= c_d;
      halt_q <= halt_d;
    end
  end

  assign mem_addr  = act_a ? irb[AW-1:0] : '0;
  assign mem_wdata = mem_wren ? acc_q : '0;
  assign pc_target = pc_load ? irb[AW-1:0] : '0;
  assign acc       = acc_q;
  assign flag_z    = z_q;
  assign flag_c    = c_q;
  assign halt      = halt_q;

  // Both strobes together means the stage controller is confused.
  always_ff @(posedge clk) begin
    if (rst && !halt_q)
      assert (!(execa && execb))
      else $warning("exec_unit: execa and execb both high; cycle treated as idle");
  end

endmodule

// File: tb/tb_exec_unit.sv
module tb_exec_unit;

`ifdef EXEC_ILLEGAL_TRAP_EN
  localparam logic TRAP = 1'b1;
`else
  localparam logic TRAP = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst, execa, execb;
  logic [7:0] ira, irb, mem_rdata;
  logic [7:0] mem_addr, mem_wdata, pc_target, acc;
  logic       mem_rden, mem_wren, pc_load, flag_z, flag_c, halt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  exec_unit #(.DW(8), .AW(8)) dut (
    .clk(clk), .rst(rst), .execa(execa), .execb(execb),
    .ira(ira), .irb(irb), .mem_rdata(mem_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rden(mem_rden), .mem_wren(mem_wren),
    .pc_load(pc_load), .pc_target(pc_target),
    .acc(acc), .flag_z(flag_z), .flag_c(flag_c), .halt(halt)
  );

  typedef struct {
    string      nm;
    logic       rst, a, b;
    logic [7:0] ira, irb, rd;
    // combinational outputs during the cycle
    logic [7:0] e_addr, e_wd;
    logic       e_rden, e_wren, e_pcl;
    logic [7:0] e_pct;
    // state after the clock edge
    logic [7:0] e_acc;
    logic       e_z, e_c, e_h;
  } vec_t;

  function automatic vec_t mk(string nm, logic r, logic a, logic b,
                              logic [7:0] ira_v, logic [7:0] irb_v, logic [7:0] rd,
                              logic [7:0] ea, logic [7:0] ewd, logic erd, logic ewr,
                              logic epl, logic [7:0] ept,
                              logic [7:0] eacc, logic ez, logic ec, logic eh);
    vec_t v;
    v.nm = nm; v.rst = r; v.a = a; v.b = b;
    v.ira = ira_v; v.irb = irb_v; v.rd = rd;
    v.e_addr = ea; v.e_wd = ewd; v.e_rden = erd; v.e_wren = ewr;
    v.e_pcl = epl; v.e_pct = ept;
    v.e_acc = eacc; v.e_z = ez; v.e_c = ec; v.e_h = eh;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    logic [33:0] got_c, exp_c;
    logic [10:0] got_s, exp_s;
    @(negedge clk);
    rst = v.rst; execa = v.a; execb = v.b;
    ira = v.ira; irb = v.irb; mem_rdata = v.rd;
    #1;
    got_c = {mem_addr, mem_wdata, mem_rden, mem_wren, pc_load, pc_target};
    exp_c = {v.e_addr, v.e_wd, v.e_rden, v.e_wren, v.e_pcl, v.e_pct};
    checks++;
    if (got_c !== exp_c) begin
      errors++;
      $display("FAIL %s req: got addr=%h wd=%h rd=%b wr=%b pcl=%b pct=%h, want addr=%h wd=%h rd=%b wr=%b pcl=%b pct=%h",
               v.nm, mem_addr, mem_wdata, mem_rden, mem_wren, pc_load, pc_target,
               v.e_addr, v.e_wd, v.e_rden, v.e_wren, v.e_pcl, v.e_pct);
    end
    @(posedge clk);
    #1;
    got_s = {acc, flag_z, flag_c, halt};
    exp_s = {v.e_acc, v.e_z, v.e_c, v.e_h};
    checks++;
    if (got_s !== exp_s) begin
      errors++;
      $display("FAIL %s state: got acc=%h z=%b c=%b h=%b, want acc=%h z=%b c=%b h=%b",
               v.nm, acc, flag_z, flag_c, halt, v.e_acc, v.e_z, v.e_c, v.e_h);
    end
  endtask

  vec_t tbl[$];

  initial begin
    rst = 1'b1; execa = 1'b0; execb = 1'b0;
    ira = 8'h00; irb = 8'h00; mem_rdata = 8'h00;

    // Scramble state with random loads (no checks), then reset for 2 cycles.
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      execb = 1'b1; ira = 8'h10; irb = 8'($urandom_range(1, 255));
    end
    apply(mk("rst0", 0,0,0, 8'h00,8'h00,8'h00, 0,0,0,0,0,0, 8'h00,0,0,0));
    apply(mk("rst1", 0,0,0, 8'h00,8'h00,8'h00, 0,0,0,0,0,0, 8'h00,0,0,0));

    //            name     r a b  ira   irb   rd    addr  wd    rd wr pl pct   acc   z c h
    tbl.push_back(mk("ldi7f_a", 1,1,0, 8'h10,8'h7F,8'h00, 8'h7F,8'h00,0,0,0,8'h00, 8'h00,0,0,0));
    tbl.push_back(mk("ldi7f_b", 1,0,1, 8'h10,8'h7F,8'h00, 8'h00,8'h00,0,0,0,8'h00, 8'h7F,0,0,0));
    tbl.push_back(mk("add_a",   1,1,0, 8'h40,8'h10,8'h00, 8'h10,8'h00,1,0,0,8'h00, 8'h7F,0,0,0));
    tbl.push_back(mk("add_b",   1,0,1, 8'h40,8'h10,8'h81, 8'h00,8'h00,0,0,0,8'h00, 8'h00,1,1,0));
    tbl.push_back(mk("jz1_a",   1,1,0, 8'h90,8'h33,8'h00, 8'h33,8'h00,0,0,0,8'h00, 8'h00,1,1,0));
    tbl.push_back(mk("jz1_b",   1,0,1, 8'h90,8'h33,8'h00, 8'h00,8'h00,0,0,1,8'h33, 8'h00,1,1,0));
    tbl.push_back(mk("ldi5a_a", 1,1,0, 8'h10,8'h5A,8'h00, 8'h5A,8'h00,0,0,0,8'h00, 8'h00,1,1,0));
    tbl.push_back(mk("ldi5a_b", 1,0,1, 8'h10,8'h5A,8'h00, 8'h00,8'h00,0,0,0,8'h00, 8'h5A,0,1,0));
    tbl.push_back(mk("st_a",    1,1,0, 8'h30,8'h20,8'h00, 8'h20,8'h5A,0,1,0,8'h00, 8'h5A,0,1,0));
    tbl.push_back(mk("st_b",    1,0,1, 8'h30,8'h20,8'h00, 8'h00,8'h00,0,0,0,8'h00, 8'h5A,0,1,0));
    tbl.push_back(mk("jz0_a",   1,1,0, 8'h90,8'h33,8'h00, 8'h33,8'h00,0,0,0,8'h00, 8'h5A,0,1,0));
    tbl.push_back(mk("jz0_b",   1,0,1, 8'h90,8'h33,8'h00, 8'h00,8'h00,0,0,0,8'h00, 8'h5A,0,1,0));
    tbl.push_back(mk("jc1_b",   1,0,1, 8'hA0,8'h44,8'h00, 8'h00,8'h00,0,0,1,8'h44, 8'h5A,0,1,0));
    tbl.push_back(mk("sub_a",   1,1,0, 8'h50,8'h11,8'h00, 8'h11,8'h00,1,0,0,8'h00, 8'h5A,0,1,0));
    tbl.push_back(mk("sub_b",   1,0,1, 8'h50,8'h11,8'h5B, 8'h00,8'h00,0,0,0,8'h00, 8'hFF,0,1,0));
    tbl.push_back(mk("and_b",   1,0,1, 8'h60,8'h11,8'h0F, 8'h00,8'h00,0,0,0,8'h00, 8'h0F,0,1,0));
    tbl.push_back(mk("or_b",    1,0,1, 8'h70,8'h11,8'hF0, 8'h00,8'h00,0,0,0,8'h00, 8'hFF,0,1,0));
    tbl.push_back(mk("addwrap", 1,0,1, 8'h40,8'h11,8'h01, 8'h00,8'h00,0,0,0,8'h00, 8'h00,1,1,0));
    tbl.push_back(mk("sub0_b",  1,0,1, 8'h50,8'h11,8'h00, 8'h00,8'h00,0,0,0,8'h00, 8'h00,1,0,0));
    tbl.push_back(mk("jc0_b",   1,0,1, 8'hA0,8'h44,8'h00, 8'h00,8'h00,0,0,0,8'h00, 8'h00,1,0,0));
    tbl.push_back(mk("ld_b",    1,0,1, 8'h20,8'h11,8'h80, 8'h00,8'h00,0,0,0,8'h00, 8'h80,0,0,0));
    tbl.push_back(mk("both",    1,1,1, 8'h10,8'h11,8'h00, 8'h00,8'h00,0,0,0,8'h00, 8'h80,0,0,0));
    tbl.push_back(mk("jmp_b",   1,0,1, 8'h80,8'h66,8'h00, 8'h00,8'h00,0,0,1,8'h66, 8'h80,0,0,0));
    tbl.push_back(mk("idle",    1,0,0, 8'h30,8'h11,8'h00, 8'h00,8'h00,0,0,0,8'h00, 8'h80,0,0,0));

    foreach (tbl[i]) apply(tbl[i]);

    // Halt is sticky and masks all strobes until reset.
    apply(mk("hlt_a",   1,1,0, 8'hF0,8'h00,8'h00, 8'h00,8'h00,0,0,0,8'h00, 8'h80,0,0,1));
    apply(mk("hltd_a",  1,1,0, 8'h10,8'h11,8'h00, 8'h00,8'h00,0,0,0,8'h00, 8'h80,0,0,1));
    apply(mk("hltd_b",  1,0,1, 8'h10,8'h11,8'h00, 8'h00,8'h00,0,0,0,8'h00, 8'h80,0,0,1));
    apply(mk("hltd_st", 1,1,0, 8'h30,8'h22,8'h00, 8'h00,8'h00,0,0,0,8'h00, 8'h80,0,0,1));
    apply(mk("hlt_rst", 0,0,0, 8'h00,8'h00,8'h00, 8'h00,8'h00,0,0,0,8'h00, 8'h00,0,0,0));

    // Undefined opcode 0xC0: trap or NOP depending on build.
    apply(mk("ill_a",   1,1,0, 8'hC0,8'h12,8'h00, 8'h12,8'h00,0,0,0,8'h00, 8'h00,0,0,TRAP));
    apply(mk("ill_b",   1,0,1, 8'hC0,8'h12,8'h00, 8'h00,8'h00,0,0,0,8'h00, 8'h00,0,0,TRAP));
    apply(mk("ill_ldi", 1,0,1, 8'h10,8'h11,8'h00, 8'h00,8'h00,0,0,0,8'h00,
             TRAP ? 8'h00 : 8'h11, 0,0,TRAP));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
